// File: rtl/cacheline_adapter_if.sv
// Bundles the cache-side line port (dfp_*) and the burst memory port (bmem_*).
// slave = adapter view, master = cache/memory environment view.
interface cacheline_adapter_if #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
);
  localparam int LINE_W = BEAT_W * BEATS;

  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts whole-line cache reads/writes into BEATS-beat bursts, one transaction at a time.
// Optional: define CACHELINE_ADAPTER_ADDR_CHECK_EN to accept only read beats tagged with the line address.
module cacheline_adapter #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input logic                clk,
  input logic                rst,
  cacheline_adapter_if.slave bus
);
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} state_t;

  state_t                         state, state_next;
  logic [CNT_W-1:0]               cnt;
  logic [31:0]                    addr_q;
  logic [BEATS-1:0][BEAT_W-1:0]   wr_line;
  logic [BEATS-1:0][BEAT_W-1:0]   rd_line;
  logic [BEATS-1:0][BEAT_W-1:0]   line_next;
  logic [LINE_W-1:0]              rdata_q;
  logic                           beat_ok;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.dfp_addr[OFFS_W-1:0];

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
  assign beat_ok = (state == RD_DATA) && bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
`else
  logic unused_raddr;
  assign unused_raddr = ^bus.bmem_raddr;
  assign beat_ok = (state == RD_DATA) && bus.bmem_rvalid;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_next      = state;
    bus.bmem_read   = 1'b0;
    bus.bmem_write  = 1'b0;
    bus.bmem_wdata  = '0;
    bus.dfp_resp    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.dfp_read)       state_next = RD_CMD;   // read wins over write
        else if (bus.dfp_write) state_next = WR_DATA;
      end
      RD_CMD: begin
        bus.bmem_read = 1'b1;
        if (bus.bmem_ready) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (beat_ok && cnt == LAST) state_next = RESP;
      end
      WR_DATA: begin
        bus.bmem_write = 1'b1;
        bus.bmem_wdata = wr_line[cnt];
        if (bus.bmem_ready && cnt == LAST) state_next = RESP;
      end
      RESP: begin
        bus.dfp_resp = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Full line as it will look once the current beat lands in its slot.
  always_comb begin
    line_next      = rd_line;
    line_next[cnt] = bus.bmem_rdata;
  end

  // NOTE: line buffers are reset too, so outputs are never X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wr_line <= '0;
      rd_line <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.dfp_read || bus.dfp_write)
            addr_q <= {bus.dfp_addr[31:OFFS_W], OFFS_W'(0)};
          if (!bus.dfp_read && bus.dfp_write)
            wr_line <= bus.dfp_wdata;
        end
        RD_DATA: begin
          if (beat_ok) begin
            rd_line[cnt] <= bus.bmem_rdata;
            cnt          <= cnt + 1'b1;
            if (cnt == LAST) rdata_q <= line_next;
          end
        end
        WR_DATA: begin
          if (bus.bmem_ready) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bmem_addr = addr_q;
  assign bus.dfp_rdata = rdata_q;
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, stalled write, gapped read, read/write priority,
// reset mid-burst and the CACHELINE_ADAPTER_ADDR_CHECK_EN address-tag filter.
module tb_cacheline_adapter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adapter_if bus ();
  cacheline_adapter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input logic [63:0] d, input logic [31:0] a);
    bus.bmem_rvalid = 1'b1;
    bus.bmem_rdata  = d;
    bus.bmem_raddr  = a;
    tick();
    bus.bmem_rvalid = 1'b0;
  endtask

  function automatic logic [255:0] b(input logic x);
    return 256'(x);
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [255:0] l1, w2, l3, l4, l5, l6;
  logic [63:0]  b3 [4];
  int           resp_cnt;

  initial begin
    l1 = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    w2 = {64'hd0d1d2d3d4d5d6d7, 64'hc0c1c2c3c4c5c6c7, 64'hb0b1b2b3b4b5b6b7, 64'ha0a1a2a3a4a5a6a7};
    b3 = '{64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f0f0f0f0f, 64'hf0f0f0f0f0f0f0f0};
    l3 = {b3[3], b3[2], b3[1], b3[0]};
    l4 = {64'hffffffffffffffff, 64'h0000000000000000, 64'haaaaaaaaaaaaaaaa, 64'h5555555555555555};
    l5 = {64'h5004000000000004, 64'h5003000000000003, 64'h5002000000000002, 64'h5001000000000001};

    rst = 1'b1;
    bus.dfp_addr = '0; bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_resp",  b(bus.dfp_resp),   '0);
    check("rst_read",  b(bus.bmem_read),  '0);
    check("rst_write", b(bus.bmem_write), '0);
    check("rst_addr",  256'(bus.bmem_addr),  '0);
    check("rst_wdata", 256'(bus.bmem_wdata), '0);
    check("rst_rdata", bus.dfp_rdata, '0);

    // 1: back-to-back read, unaligned address
    bus.dfp_addr = 32'h1eceb004; bus.dfp_read = 1'b1; bus.bmem_ready = 1'b1;
    tick();
    check("t1_cmd",  b(bus.bmem_read), 256'(1'b1));
    check("t1_addr", 256'(bus.bmem_addr), 256'(32'h1eceb000));
    tick();
    check("t1_cmd_once", b(bus.bmem_read), '0);
    beat(l1[63:0],    32'h1eceb000);
    beat(l1[127:64],  32'h1eceb000);
    beat(l1[191:128], 32'h1eceb000);
    check("t1_no_early_resp", b(bus.dfp_resp), '0);
    beat(l1[255:192], 32'h1eceb000);
    check("t1_resp",  b(bus.dfp_resp), 256'(1'b1));
    check("t1_rdata", bus.dfp_rdata, l1);
    tick();
    bus.dfp_read = 1'b0;
    check("t1_resp_pulse", b(bus.dfp_resp), '0);
    check("t1_req_ignored", b(bus.bmem_read), '0);
    tick();
    check("t1_no_reissue", b(bus.bmem_read), '0);

    // 2: write with ready low for two cycles mid-burst
    bus.dfp_addr = 32'h1eceb020; bus.dfp_write = 1'b1; bus.dfp_wdata = w2; bus.bmem_ready = 1'b1;
    tick();
    bus.dfp_wdata = '0;
    check("t2_write", b(bus.bmem_write), 256'(1'b1));
    check("t2_noread", b(bus.bmem_read), '0);
    check("t2_addr", 256'(bus.bmem_addr), 256'(32'h1eceb020));
    check("t2_b0", 256'(bus.bmem_wdata), 256'(w2[63:0]));
    tick();
    check("t2_b1", 256'(bus.bmem_wdata), 256'(w2[127:64]));
    bus.bmem_ready = 1'b0;
    tick();
    check("t2_hold1", 256'(bus.bmem_wdata), 256'(w2[127:64]));
    tick();
    check("t2_hold2", 256'(bus.bmem_wdata), 256'(w2[127:64]));
    check("t2_hold_write", b(bus.bmem_write), 256'(1'b1));
    bus.bmem_ready = 1'b1;
    tick();
    check("t2_b2", 256'(bus.bmem_wdata), 256'(w2[191:128]));
    check("t2_no_early_resp", b(bus.dfp_resp), '0);
    tick();
    check("t2_b3", 256'(bus.bmem_wdata), 256'(w2[255:192]));
    tick();
    check("t2_resp", b(bus.dfp_resp), 256'(1'b1));
    check("t2_write_done", b(bus.bmem_write), '0);
    check("t2_rdata_stable", bus.dfp_rdata, l1);
    bus.dfp_write = 1'b0;
    tick();
    check("t2_resp_pulse", b(bus.dfp_resp), '0);

    // 3: command stalled one cycle, then three idle cycles between beats
    bus.dfp_addr = 32'h00000040; bus.dfp_read = 1'b1; bus.bmem_ready = 1'b0;
    tick();
    check("t3_cmd", b(bus.bmem_read), 256'(1'b1));
    tick();
    check("t3_cmd_wait", b(bus.bmem_read), 256'(1'b1));
    bus.bmem_ready = 1'b1;
    tick();
    check("t3_cmd_done", b(bus.bmem_read), '0);
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      beat(b3[i], 32'h00000040);
      if (i < 3) begin
        for (int k = 0; k < 3; k++) begin
          if (bus.dfp_resp) resp_cnt++;
          tick();
        end
      end
    end
    check("t3_gap_no_resp", 256'(resp_cnt), '0);
    check("t3_resp",  b(bus.dfp_resp), 256'(1'b1));
    check("t3_rdata", bus.dfp_rdata, l3);
    bus.dfp_read = 1'b0;
    tick();
    check("t3_resp_pulse", b(bus.dfp_resp), '0);

    // 4: read and write together -> read wins
    bus.dfp_addr = 32'h2000007f; bus.dfp_read = 1'b1; bus.dfp_write = 1'b1; bus.dfp_wdata = w2;
    tick();
    check("t4_read",  b(bus.bmem_read),  256'(1'b1));
    check("t4_write", b(bus.bmem_write), '0);
    check("t4_addr",  256'(bus.bmem_addr), 256'(32'h20000060));
    tick();
    check("t4_write_data_phase", b(bus.bmem_write), '0);
    beat(l4[63:0],    32'h20000060);
    beat(l4[127:64],  32'h20000060);
    beat(l4[191:128], 32'h20000060);
    beat(l4[255:192], 32'h20000060);
    check("t4_resp",  b(bus.dfp_resp), 256'(1'b1));
    check("t4_rdata", bus.dfp_rdata, l4);
    bus.dfp_read = 1'b0; bus.dfp_write = 1'b0;
    tick();

    // 5: reset after two beats, late beats dropped, next read completes
    bus.dfp_addr = 32'h00001000; bus.dfp_read = 1'b1;
    tick();
    tick();
    beat(64'h7777000000000000, 32'h00001000);
    beat(64'h7777000000000001, 32'h00001000);
    rst = 1'b1; bus.dfp_read = 1'b0;
    tick();
    rst = 1'b0;
    check("t5_rst_resp",  b(bus.dfp_resp), '0);
    check("t5_rst_read",  b(bus.bmem_read), '0);
    check("t5_rst_rdata", bus.dfp_rdata, '0);
    beat(64'h7777000000000002, 32'h00001000);
    check("t5_late3_resp", b(bus.dfp_resp), '0);
    beat(64'h7777000000000003, 32'h00001000);
    check("t5_late4_resp", b(bus.dfp_resp), '0);
    tick();
    check("t5_idle_resp", b(bus.dfp_resp), '0);
    bus.dfp_read = 1'b1;
    tick();
    check("t5_cmd", b(bus.bmem_read), 256'(1'b1));
    tick();
    beat(l5[63:0],    32'h00001000);
    beat(l5[127:64],  32'h00001000);
    beat(l5[191:128], 32'h00001000);
    beat(l5[255:192], 32'h00001000);
    check("t5_resp",  b(bus.dfp_resp), 256'(1'b1));
    check("t5_rdata", bus.dfp_rdata, l5);
    bus.dfp_read = 1'b0;
    tick();

    // 6: untagged beat inserted ahead of the four tagged beats
    bus.dfp_addr = 32'h00002000; bus.dfp_read = 1'b1;
    tick();
    tick();
    beat(64'hbad0bad0bad0bad0, 32'h00000000);
    beat(64'h6000000000000000, 32'h00002000);
    beat(64'h6000000000000001, 32'h00002000);
    beat(64'h6000000000000002, 32'h00002000);
`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
    l6 = {64'h6000000000000003, 64'h6000000000000002, 64'h6000000000000001, 64'h6000000000000000};
    check("t6_no_early_resp", b(bus.dfp_resp), '0);
    beat(64'h6000000000000003, 32'h00002000);
    check("t6_resp",  b(bus.dfp_resp), 256'(1'b1));
    check("t6_rdata", bus.dfp_rdata, l6);
    bus.dfp_read = 1'b0;
    tick();
`else
    l6 = {64'h6000000000000002, 64'h6000000000000001, 64'h6000000000000000, 64'hbad0bad0bad0bad0};
    check("t6_resp",  b(bus.dfp_resp), 256'(1'b1));
    check("t6_rdata", bus.dfp_rdata, l6);
    bus.dfp_read = 1'b0;
    beat(64'h6000000000000003, 32'h00002000);
`endif
    check("t6_resp_pulse", b(bus.dfp_resp), '0);
    check("t6_idle_read",  b(bus.bmem_read), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
